// File: rtl/arb_mux_rr.sv
// N-channel arbiter feeding a single registered output stage with valid/ready handshakes.
// Define ARB_MUX_RR_EN for round-robin arbitration; by default the lowest valid index wins.
module arb_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_sel
);

    logic             load_en;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] grant_data;

    // The stage can take a word whenever it is empty or being drained this cycle.
    assign load_en  = ~out_valid | out_ready;
    assign in_ready = reset ? '0 : (grant & {N{load_en}});

`ifdef ARB_MUX_RR_EN
    logic [SW-1:0] ptr;

    // Search starts one past the last winner and wraps at N-1, so idx never reaches N.
    always_comb begin
        logic [SW-1:0] idx;
        // NOTE: every combinational output gets a default before any branch; a path
        // that leaves one unassigned would infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = (ptr == SW'(N - 1)) ? '0 : ptr + 1'b1;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && in_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
            idx = (idx == SW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= SW'(N - 1);
        end else if (load_en && grant_any) begin
            ptr <= grant_idx;
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && in_valid[k]) begin
                grant[k]  = 1'b1;
                grant_idx = SW'(k);
                grant_any = 1'b1;
            end
        end
    end
`endif

    // grant is one-hot or zero, so at most one term of this mux is live.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_data <= grant_data;
                out_sel  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr: a 4-channel and a 3-channel instance, expectations
// switch between round-robin and fixed-priority with ARB_MUX_RR_EN.
module tb_arb_mux_rr;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int N3    = 3;
`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           out_sel;

    logic [N3-1:0]        in_valid3;
    logic [N3*WIDTH-1:0]  in_data3;
    logic [N3-1:0]        in_ready3;
    logic                 out_valid3;
    logic                 out_ready3;
    logic [WIDTH-1:0]     out_data3;
    logic [1:0]           out_sel3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arb_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    arb_mux_rr #(.WIDTH(WIDTH), .N(N3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_sel(out_sel3)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic load_pattern_data();
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hA000_0000 | i;
        for (int i = 0; i < N3; i++) in_data3[i*WIDTH +: WIDTH] = 32'hB000_0000 | i;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = '0;
        in_valid3  = '0;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 4'b1111;
        in_valid3  = 3'b111;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        load_pattern_data();
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL reset_in_ready3 got=%b exp=000", in_ready3); end
        // Idle with the stage empty: out_valid must stay low.
        @(negedge clk);
        reset    = 1'b0;
        in_valid = '0;
        in_valid3 = '0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [1:0] exp_sel;
        do_reset();
        load_pattern_data();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL sweep_first_ready got=%b exp=0001", in_ready); end
        for (int k = 0; k < 5; k++) begin
            exp_sel = RR ? 2'(k % 4) : 2'd0;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid[%0d] got=%b exp=1", k, out_valid); end
            checks++; if (out_sel !== exp_sel) begin errors++; $display("FAIL sweep_sel[%0d] got=%0d exp=%0d", k, out_sel, exp_sel); end
            checks++; if (out_data !== (32'hA000_0000 | 32'(exp_sel))) begin
                errors++; $display("FAIL sweep_data[%0d] got=%h exp=%h", k, out_data, 32'hA000_0000 | 32'(exp_sel)); end
            checks++; if ($countones(in_ready) > 1) begin errors++; $display("FAIL sweep_onehot[%0d] got=%b exp=<=1 bit", k, in_ready); end
        end
    endtask

    task automatic test_stall();
        int acc = 0;
        int outx = 0;
        do_reset();
        load_pattern_data();
        in_data[2*WIDTH +: WIDTH] = 32'h1234_5678;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL stall_first_ready got=%b exp=0100", in_ready); end
        for (int c = 1; c <= 4; c++) begin
            if ((in_valid & in_ready) != '0) acc++;
            if (out_valid && out_ready) outx++;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, out_valid); end
            checks++; if (out_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=12345678", c, out_data); end
            checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL stall_sel[%0d] got=%0d exp=2", c, out_sel); end
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", c, in_ready); end
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        #1;
        if ((in_valid & in_ready) != '0) acc++;
        if (out_valid && out_ready) outx++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h1234_5678) begin errors++; $display("FAIL drain_data_hold got=%h exp=12345678", out_data); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL drain_sel_hold got=%0d exp=2", out_sel); end
        checks++; if (acc !== 1) begin errors++; $display("FAIL stall_accepts got=%0d exp=1", acc); end
        checks++; if (outx !== 1) begin errors++; $display("FAIL stall_out_transfers got=%0d exp=1", outx); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_rr [3] = '{2'd0, 2'd3, 2'd0};
        logic [1:0] exp_sel;
        do_reset();
        load_pattern_data();
        in_valid  = 4'b1001;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_sel = RR ? exp_rr[k] : 2'd0;
            #1;
            checks++; if (in_ready !== (4'b0001 << exp_sel)) begin
                errors++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << exp_sel); end
            @(posedge clk); #1;
            checks++; if (out_sel !== exp_sel) begin errors++; $display("FAIL wrap_sel[%0d] got=%0d exp=%0d", k, out_sel, exp_sel); end
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp_rr [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [1:0] exp_sel;
        do_reset();
        load_pattern_data();
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_sel = RR ? exp_rr[k] : 2'd1;
            #1;
            checks++; if (in_ready[3] !== (exp_sel == 2'd3)) begin
                errors++; $display("FAIL prio_ready3[%0d] got=%b exp=%b", k, in_ready[3], exp_sel == 2'd3); end
            @(posedge clk); #1;
            checks++; if (out_sel !== exp_sel) begin errors++; $display("FAIL prio_sel[%0d] got=%0d exp=%0d", k, out_sel, exp_sel); end
            checks++; if (out_data !== (32'hA000_0000 | 32'(exp_sel))) begin
                errors++; $display("FAIL prio_data[%0d] got=%h exp=%h", k, out_data, 32'hA000_0000 | 32'(exp_sel)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_pattern_data();
        in_data[2*WIDTH +: WIDTH] = 32'h1234_5678;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got=%b exp=1", out_valid); end
        reset    = 1'b1;
        in_valid = 4'b1111;
        load_pattern_data();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_data got=%h exp=0", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL mid_sel got=%0d exp=0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_in_ready got=%b exp=0000", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_held_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_next_ready got=%b exp=0001", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL mid_next_sel got=%0d exp=0", out_sel); end
        checks++; if (out_data !== 32'hA000_0000) begin errors++; $display("FAIL mid_next_data got=%h exp=a0000000", out_data); end
    endtask

    task automatic test_n3();
        logic [1:0] exp_rr [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [1:0] exp_sel;
        do_reset();
        load_pattern_data();
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_sel = RR ? exp_rr[k] : 2'd0;
            @(posedge clk); #1;
            checks++; if (out_valid3 !== 1'b1) begin errors++; $display("FAIL n3_valid[%0d] got=%b exp=1", k, out_valid3); end
            checks++; if (out_sel3 !== exp_sel) begin errors++; $display("FAIL n3_sel[%0d] got=%0d exp=%0d", k, out_sel3, exp_sel); end
            checks++; if (out_sel3 > 2'd2) begin errors++; $display("FAIL n3_range[%0d] got=%0d exp=<3", k, out_sel3); end
            checks++; if (out_data3 !== (32'hB000_0000 | 32'(exp_sel))) begin
                errors++; $display("FAIL n3_data[%0d] got=%h exp=%h", k, out_data3, 32'hB000_0000 | 32'(exp_sel)); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = '0;
        in_valid3  = '0;
        in_data    = '0;
        in_data3   = '0;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        test_reset();
        test_sweep();
        test_stall();
        test_wrap();
        test_fixed_priority();
        test_reset_mid();
        test_n3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
